// File: rtl/feature_pkg.sv
`default_nettype none
// ============================================================================
// Module      : feature_pkg
// Description : Shared types for the feature matcher and match consumers.
// Revision    : 1.0 - initial release
// ============================================================================
package feature_pkg;

    localparam int unsigned c_FEAT_PW  = 10;
    localparam int unsigned c_FEAT_FCW = 10;

    typedef struct packed {
        logic [c_FEAT_PW-1:0]  xs;
        logic [c_FEAT_PW-1:0]  ys;
        logic [c_FEAT_PW-1:0]  xe;
        logic [c_FEAT_PW-1:0]  ye;
        logic [c_FEAT_FCW-1:0] span;
    } match_t;

    typedef enum logic [1:0] {
        M_IDLE   = 2'd0,
        M_DIVIDE = 2'd1,
        M_HOLD   = 2'd2
    } motion_state_e;

endpackage
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Unsigned restoring divider, one quotient bit per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int W  = 19,
    parameter int QW = W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  dividend,
    input  logic [W-1:0]  divisor,
    output logic          busy,
    output logic          done,
    output logic [QW-1:0] quotient
);

    localparam int c_CNT_W = $clog2(W + 1);

    logic [W-1:0]       r_q;
    logic [W-1:0]       r_rem;
    logic [W-1:0]       r_div;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_done;
    logic [W:0]         w_shift;
    logic [W:0]         w_trial;

    // r_q holds the remaining dividend bits in its top and collects quotient bits at the bottom
    assign w_shift = {r_rem, r_q[W-1]};
    assign w_trial = w_shift - {1'b0, r_div};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= '0;
            r_rem  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start && (r_cnt == '0)) begin
                r_q   <= dividend;
                r_rem <= '0;
                r_div <= divisor;
                r_cnt <= c_CNT_W'(W);
            end else if (r_cnt != '0) begin
                if (!w_trial[W]) begin
                    r_rem <= w_trial[W-1:0];
                    r_q   <= {r_q[W-2:0], 1'b1};
                end else begin
                    r_rem <= w_shift[W-1:0];
                    r_q   <= {r_q[W-2:0], 1'b0};
                end
                r_cnt  <= r_cnt - c_CNT_W'(1);
                r_done <= (r_cnt == c_CNT_W'(1));
            end
        end
    end

    assign busy     = (r_cnt != '0);
    assign done     = r_done;
    assign quotient = r_q[QW-1:0];

endmodule
`default_nettype wire

// File: rtl/match_motion_estimator.sv
`default_nettype none
// ============================================================================
// Module      : match_motion_estimator
// Description : Accumulates accepted match displacements per frame and emits
//               the mean global motion vector on a valid/ready output.
// Revision    : 1.0 - initial release
// ============================================================================
module match_motion_estimator
    import feature_pkg::*;
#(
    parameter int PW       = 10,
    parameter int FCW      = 10,
    parameter int CW       = 8,
    parameter int MAX_DISP = 64,
    parameter int MIN_SPAN = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           new_frame,
    input  logic           match_flag,
    input  logic [PW-1:0]  match_xs,
    input  logic [PW-1:0]  match_ys,
    input  logic [PW-1:0]  match_xe,
    input  logic [PW-1:0]  match_ye,
    input  logic [FCW-1:0] match_span,
    output logic           motion_valid,
    input  logic           motion_ready,
    output logic [PW:0]    motion_dx,
    output logic [PW:0]    motion_dy,
    output logic [CW-1:0]  motion_count,
    output logic           overrun
);

    localparam int c_AW = PW + 1 + CW;

    motion_state_e r_state;
    motion_state_e w_state_nxt;

    logic [c_AW-1:0] r_sum_dx, r_sum_dy;
    logic [CW-1:0]   r_count, r_cnt_snap;
    logic            r_neg_dx, r_neg_dy;

    logic [PW:0]     w_dx, w_dy, w_adx, w_ady;
    logic [c_AW-1:0] w_base_sx, w_base_sy, w_abs_sx, w_abs_sy, w_divisor;
    logic [CW-1:0]   w_base_cnt;
    logic            w_accept;
    logic            w_start, w_load_div, w_load_zero;
    logic            w_busy_x, w_busy_y, w_done_x, w_done_y, w_div_fin;
    logic [PW:0]     w_qx, w_qy;

    // Modular PW+1-bit subtraction equals the signed difference of zero-extended positions
    assign w_dx  = {1'b0, match_xe} - {1'b0, match_xs};
    assign w_dy  = {1'b0, match_ye} - {1'b0, match_ys};
    assign w_adx = w_dx[PW] ? -w_dx : w_dx;
    assign w_ady = w_dy[PW] ? -w_dy : w_dy;

    // A match arriving with new_frame belongs to the frame that is starting
    assign w_base_sx  = new_frame ? '0 : r_sum_dx;
    assign w_base_sy  = new_frame ? '0 : r_sum_dy;
    assign w_base_cnt = new_frame ? '0 : r_count;

    assign w_accept = match_flag
                   && (match_span >= FCW'(MIN_SPAN))
                   && (w_adx <= (PW+1)'(MAX_DISP))
                   && (w_ady <= (PW+1)'(MAX_DISP))
                   && (w_base_cnt != '1);

    assign w_abs_sx  = r_sum_dx[c_AW-1] ? -r_sum_dx : r_sum_dx;
    assign w_abs_sy  = r_sum_dy[c_AW-1] ? -r_sum_dy : r_sum_dy;
    assign w_divisor = {{(c_AW-CW){1'b0}}, r_count};
    assign w_div_fin = w_done_x && w_done_y && !w_busy_x && !w_busy_y;

    seq_divider #(.W(c_AW), .QW(PW+1)) u_div_x (
        .clk      (clk),
        .rst      (rst),
        .start    (w_start),
        .dividend (w_abs_sx),
        .divisor  (w_divisor),
        .busy     (w_busy_x),
        .done     (w_done_x),
        .quotient (w_qx)
    );

    seq_divider #(.W(c_AW), .QW(PW+1)) u_div_y (
        .clk      (clk),
        .rst      (rst),
        .start    (w_start),
        .dividend (w_abs_sy),
        .divisor  (w_divisor),
        .busy     (w_busy_y),
        .done     (w_done_y),
        .quotient (w_qy)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= M_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_load_div  = 1'b0;
        w_load_zero = 1'b0;
        case (r_state)
            M_IDLE: begin
                if (new_frame) begin
                    if (r_count == '0) begin
                        w_state_nxt = M_HOLD;
                        w_load_zero = 1'b1;
                    end else begin
                        w_state_nxt = M_DIVIDE;
                        w_start     = 1'b1;
                    end
                end
            end
            M_DIVIDE: begin
                if (w_div_fin) begin
                    w_state_nxt = M_HOLD;
                    w_load_div  = 1'b1;
                end
            end
            M_HOLD: begin
                if (motion_ready) w_state_nxt = M_IDLE;
            end
            default: w_state_nxt = M_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum_dx     <= '0;
            r_sum_dy     <= '0;
            r_count      <= '0;
            r_cnt_snap   <= '0;
            r_neg_dx     <= 1'b0;
            r_neg_dy     <= 1'b0;
            motion_dx    <= '0;
            motion_dy    <= '0;
            motion_count <= '0;
            overrun      <= 1'b0;
        end else begin
            r_sum_dx <= w_base_sx + (w_accept ? {{(c_AW-PW-1){w_dx[PW]}}, w_dx} : '0);
            r_sum_dy <= w_base_sy + (w_accept ? {{(c_AW-PW-1){w_dy[PW]}}, w_dy} : '0);
            r_count  <= w_base_cnt + {{(CW-1){1'b0}}, w_accept};
            if (new_frame && (r_state != M_IDLE)) overrun <= 1'b1;
            if (w_start) begin
                r_neg_dx   <= r_sum_dx[c_AW-1];
                r_neg_dy   <= r_sum_dy[c_AW-1];
                r_cnt_snap <= r_count;
            end
            if (w_load_zero) begin
                motion_dx    <= '0;
                motion_dy    <= '0;
                motion_count <= '0;
            end
            // Magnitude division then sign restore gives truncation toward zero
            if (w_load_div) begin
                motion_dx    <= r_neg_dx ? -w_qx : w_qx;
                motion_dy    <= r_neg_dy ? -w_qy : w_qy;
                motion_count <= r_cnt_snap;
            end
        end
    end

    assign motion_valid = (r_state == M_HOLD);

endmodule
`default_nettype wire
